// File: rtl/spi_frame_decoder.sv
// +----------------------------------------------------------------------------+
// | spi_frame_decoder                                                          |
// | SPI mode-0 slave frame decoder: R/W bit, address, data -> register strobes.|
// | Optional frame_err output enabled by macro SPI_FRAME_DECODER_ERR_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_frame_decoder #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              rstb,
   input  logic              clk,
   input  logic              ena,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata
`ifdef SPI_FRAME_DECODER_ERR_EN
   ,
   output logic              frame_err
`endif
);

   localparam int c_FL = 1 + ADDR_W + DATA_W;
   localparam int c_CW = $clog2(c_FL + 1);
   localparam int c_TW = $clog2(DATA_W + 1);
   localparam logic [c_CW-1:0] c_ADDR_LAST  = c_CW'(ADDR_W);
   localparam logic [c_CW-1:0] c_FRAME_LAST = c_CW'(c_FL - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CMD  = 2'd1;
   localparam logic [1:0] c_DATA = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]        r_state;
   logic              r_sclk_d;
   logic              r_cs_d;
   logic [c_CW-1:0]   r_bit_cnt;
   logic [c_FL-1:0]   r_shift;
   logic [DATA_W-1:0] r_tx;
   logic [c_TW-1:0]   r_tx_cnt;
   logic              r_miso;
   logic              r_we;
   logic              r_re;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_active;
   logic              w_rise;
   logic              w_fall;
   logic [c_FL-1:0]   w_shift_next;

   assign w_active     = ~spi_cs_n & ena;
   assign w_rise       = w_active & spi_sclk & ~r_sclk_d;
   assign w_fall       = w_active & ~spi_sclk & r_sclk_d;
   assign w_shift_next = {r_shift[c_FL-2:0], spi_mosi};

   // r_cs_d resets low so a frame already in progress at reset release is skipped
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state   <= c_IDLE;
         r_sclk_d  <= 1'b0;
         r_cs_d    <= 1'b0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_tx      <= '0;
         r_tx_cnt  <= '0;
         r_miso    <= 1'b0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_sclk_d <= spi_sclk;
         r_cs_d   <= spi_cs_n;
         r_we     <= 1'b0;
         r_re     <= 1'b0;
         if (!w_active) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= '0;
            r_tx_cnt  <= '0;
            r_miso    <= 1'b0;
         end else begin
            case (r_state)
               c_IDLE: begin
                  r_bit_cnt <= '0;
                  r_tx_cnt  <= '0;
                  r_miso    <= 1'b0;
                  if (r_cs_d) begin
                     r_state <= c_CMD;
                  end
               end
               c_CMD: begin
                  if (w_rise) begin
                     r_shift   <= w_shift_next;
                     r_bit_cnt <= r_bit_cnt + c_CW'(1);
                     if (r_bit_cnt == c_ADDR_LAST) begin
                        r_addr  <= w_shift_next[ADDR_W-1:0];
                        r_re    <= ~w_shift_next[ADDR_W];
                        r_state <= c_DATA;
                     end
                  end
               end
               c_DATA: begin
                  // reg_rdata is valid while reg_re is high, so load the shifter then
                  if (r_re) begin
                     r_tx     <= reg_rdata;
                     r_tx_cnt <= c_TW'(DATA_W);
                  end else if (w_fall) begin
                     if (r_tx_cnt != '0) begin
                        r_miso   <= r_tx[DATA_W-1];
                        r_tx     <= r_tx << 1;
                        r_tx_cnt <= r_tx_cnt - c_TW'(1);
                     end else begin
                        r_miso <= 1'b0;
                     end
                  end
                  if (w_rise) begin
                     r_shift   <= w_shift_next;
                     r_bit_cnt <= r_bit_cnt + c_CW'(1);
                     if (r_bit_cnt == c_FRAME_LAST) begin
                        if (w_shift_next[c_FL-1]) begin
                           r_wdata <= w_shift_next[DATA_W-1:0];
                        end
                        r_we    <= w_shift_next[c_FL-1];
                        r_state <= c_DONE;
                     end
                  end
               end
               default: begin
                  r_miso <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SPI_FRAME_DECODER_ERR_EN
   logic r_frame_err;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= spi_cs_n & ((r_state == c_CMD) | (r_state == c_DATA));
      end
   end

   assign frame_err = r_frame_err;
`endif

   assign spi_miso  = r_miso;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_we    = r_we;
   assign reg_re    = r_re;

endmodule

`default_nettype wire
